// File: rtl/pla_eval_arbiter_if.sv
// Request/response bus between the requesters and pla_eval_arbiter.
// master = requester/driver side, slave = arbiter side.
interface pla_eval_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned XW   = 6
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*XW-1:0] req_x;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [XW-1:0]      rsp_x;
    logic               rsp_y;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y
    );
endinterface

// File: rtl/pla_eval_arbiter.sv
// pla_eval_arbiter: round-robin sharing of one external combinational
// 6-in/1-out PLA evaluator between NREQ requesters. Each granted vector is
// driven from a register for one cycle, the result is sampled and returned
// with its requester id over a valid/ready response channel.
// Optional truth-table sweep mode: define PLA_EVAL_SWEEP_EN.
module pla_eval_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned XW   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    pla_eval_arbiter_if.slave bus,
    output logic [XW-1:0]     pla_x,
    input  logic              pla_y,
    output logic              busy
`ifdef PLA_EVAL_SWEEP_EN
    ,
    input  logic              sweep_start,
    output logic              sweep_done,
    output logic [63:0]       tt
`endif
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
`ifdef PLA_EVAL_SWEEP_EN
        ,
        SWEEP = 2'd3
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [XW-1:0]   x_q, x_d;
    logic            y_q, y_d;
    logic [XW-1:0]   pla_x_q, pla_x_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] req_ready_c;
    logic            grant_vld;
    logic [IDW-1:0]  grant_idx;
    logic [XW-1:0]   req_x_arr [NREQ];

`ifdef PLA_EVAL_SWEEP_EN
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     tt_q, tt_d;
    logic            done_q, done_d;
`endif

    // Split the flat request vector bus into one entry per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_x_arr[i] = bus.req_x[i*XW +: XW];
    end

    // Round-robin pick: first valid requester after the last one granted.
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!grant_vld && bus.req_valid[IDW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        x_d         = x_q;
        y_d         = y_q;
        pla_x_d     = pla_x_q;
        req_ready_c = '0;
`ifdef PLA_EVAL_SWEEP_EN
        cnt_d       = cnt_q;
        tt_d        = tt_q;
        done_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef PLA_EVAL_SWEEP_EN
                if (sweep_start) begin
                    tt_d    = '0;
                    cnt_d   = '0;
                    pla_x_d = '0;
                    state_d = SWEEP;
                end else
`endif
                if (grant_vld) begin
                    req_ready_c[grant_idx] = 1'b1;
                    x_d     = req_x_arr[grant_idx];
                    pla_x_d = req_x_arr[grant_idx];
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                y_d     = pla_y;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef PLA_EVAL_SWEEP_EN
            SWEEP: begin
                tt_d[cnt_q] = pla_y;
                cnt_d       = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(63)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    pla_x_d = XW'(cnt_q + 1'b1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            x_q         <= '0;
            y_q         <= 1'b0;
            pla_x_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PLA_EVAL_SWEEP_EN
            cnt_q       <= '0;
            tt_q        <= '0;
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pla_x_q     <= pla_x_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef PLA_EVAL_SWEEP_EN
            cnt_q       <= cnt_d;
            tt_q        <= tt_d;
            done_q      <= done_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_x     = x_q;
    assign bus.rsp_y     = y_q;
    assign pla_x         = pla_x_q;
    assign busy          = busy_q;
`ifdef PLA_EVAL_SWEEP_EN
    assign sweep_done    = done_q;
    assign tt            = tt_q;
`endif

endmodule
